// File: rtl/fp16_add_normalize.sv
// FP16 add/normalise back end: signed add of pre-aligned mantissas, then a
// one-bit-per-cycle normaliser packing an IEEE half-precision result.
module fp16_add_normalize #(
    parameter int MANT_W  = 11,
    parameter int EXP_W   = 5,
    parameter int EXP_MAX = 31
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    sign_A,
    input  logic                    sign_B,
    input  logic [MANT_W-1:0]       mantissa_A,
    input  logic [MANT_W-1:0]       mantissa_B,
    input  logic [EXP_W-1:0]        exponent_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [EXP_W+MANT_W-1:0] result,
    output logic                    overflow
);

    typedef enum logic [1:0] {IDLE, ADD, NORM, DONE} state_t;

    localparam logic [EXP_W:0] EXP_LIMIT = (EXP_W+1)'(EXP_MAX);

    state_t                    state_q, state_d;
    logic                      sign_a_q, sign_a_d;
    logic                      sign_b_q, sign_b_d;
    logic [MANT_W-1:0]         mant_a_q, mant_a_d;
    logic [MANT_W-1:0]         mant_b_q, mant_b_d;
    logic [EXP_W-1:0]          exp_in_q, exp_in_d;
    logic [MANT_W:0]           sum_q, sum_d;
    logic                      sign_q, sign_d;
    logic [EXP_W-1:0]          exp_q, exp_d;
    logic [3:0]                shift_cnt_q, shift_cnt_d;
    logic [EXP_W+MANT_W-1:0]   result_q, result_d;
    logic                      overflow_q, overflow_d;
    logic [EXP_W:0]            exp_inc;

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign overflow  = overflow_q;
    assign exp_inc   = {1'b0, exp_q} + (EXP_W+1)'(1);

    always_comb begin
        state_d     = state_q;
        sign_a_d    = sign_a_q;
        sign_b_d    = sign_b_q;
        mant_a_d    = mant_a_q;
        mant_b_d    = mant_b_q;
        exp_in_d    = exp_in_q;
        sum_d       = sum_q;
        sign_d      = sign_q;
        exp_d       = exp_q;
        shift_cnt_d = shift_cnt_q;
        result_d    = result_q;
        overflow_d  = overflow_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_a_d    = sign_A;
                    sign_b_d    = sign_B;
                    mant_a_d    = mantissa_A;
                    mant_b_d    = mantissa_B;
                    exp_in_d    = exponent_in;
                    shift_cnt_d = '0;
                    overflow_d  = 1'b0;
                    state_d     = ADD;
                end
            end
            ADD: begin
                // Magnitude subtract keeps the sum unsigned; sign follows the larger operand.
                if (sign_a_q == sign_b_q) begin
                    sum_d  = {1'b0, mant_a_q} + {1'b0, mant_b_q};
                    sign_d = sign_a_q;
                end else if (mant_a_q >= mant_b_q) begin
                    sum_d  = {1'b0, mant_a_q} - {1'b0, mant_b_q};
                    sign_d = sign_a_q;
                end else begin
                    sum_d  = {1'b0, mant_b_q} - {1'b0, mant_a_q};
                    sign_d = sign_b_q;
                end
                exp_d   = exp_in_q;
                state_d = NORM;
            end
            NORM: begin
                if (sum_q == '0) begin
                    result_d = '0;
                    state_d  = DONE;
                end else if (sum_q[MANT_W]) begin
                    sum_d = sum_q >> 1;
                    exp_d = exp_inc[EXP_W-1:0];
                    if (exp_inc >= EXP_LIMIT) begin
                        result_d   = {sign_q, {EXP_W{1'b1}}, {(MANT_W-1){1'b0}}};
                        overflow_d = 1'b1;
                    end else begin
                        result_d = {sign_q, exp_inc[EXP_W-1:0], sum_q[MANT_W-1:1]};
                    end
                    state_d = DONE;
                end else if (sum_q[MANT_W-1]) begin
                    result_d = {sign_q, exp_q, sum_q[MANT_W-2:0]};
                    state_d  = DONE;
                end else if (exp_q <= EXP_W'(1)) begin
                    // No denormal support: anything that would need one flushes to +0.
                    result_d = '0;
                    state_d  = DONE;
                end else begin
                    sum_d       = sum_q << 1;
                    exp_d       = exp_q - EXP_W'(1);
                    shift_cnt_d = shift_cnt_q + 4'd1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    overflow_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            sign_a_q    <= 1'b0;
            sign_b_q    <= 1'b0;
            mant_a_q    <= '0;
            mant_b_q    <= '0;
            exp_in_q    <= '0;
            sum_q       <= '0;
            sign_q      <= 1'b0;
            exp_q       <= '0;
            shift_cnt_q <= '0;
            result_q    <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sign_a_q    <= sign_a_d;
            sign_b_q    <= sign_b_d;
            mant_a_q    <= mant_a_d;
            mant_b_q    <= mant_b_d;
            exp_in_q    <= exp_in_d;
            sum_q       <= sum_d;
            sign_q      <= sign_d;
            exp_q       <= exp_d;
            shift_cnt_q <= shift_cnt_d;
            result_q    <= result_d;
            overflow_q  <= overflow_d;
            // A nonzero 12-bit sum reaches bit 10 within ten left shifts.
            if (state_q == NORM) assert (shift_cnt_q <= 4'd10);
        end
    end

endmodule
